// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pwm_ctrl_pkg : register map constants for the PWM channel ctrl   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package pwm_ctrl_pkg;

    typedef logic [2:0] reg_off_t;

    localparam reg_off_t c_OFF_CTRL   = 3'd0;
    localparam reg_off_t c_OFF_PERIOD = 3'd1;
    localparam reg_off_t c_OFF_STEP   = 3'd2;
    localparam reg_off_t c_OFF_THR1   = 3'd3;
    localparam reg_off_t c_OFF_THR2   = 3'd4;
    localparam reg_off_t c_OFF_INC    = 3'd5;
    localparam reg_off_t c_OFF_STATUS = 3'd6;

    localparam int c_CTRL_EN_BIT   = 0;
    localparam int c_CTRL_MODE_BIT = 1;
    localparam int c_CTRL_UPD_BIT  = 2;

    localparam int c_STAT_PEND_BIT = 0;
    localparam int c_STAT_EN_BIT   = 1;
    localparam int c_STAT_MODE_BIT = 2;

    localparam logic c_RSP_OK         = 1'b0;
    localparam logic c_RSP_ERR_DECODE = 1'b1;

endpackage : pwm_ctrl_pkg
`default_nettype wire

// File: rtl/pwm_ctrl_channel_regs.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pwm_ctrl_channel_regs : shadow/active registers of one channel   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module pwm_ctrl_channel_regs
    import pwm_ctrl_pkg::*;
#(
    parameter int Resolution = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_wr_en,
    input  logic [2:0]            i_off,
    input  logic [31:0]           i_wdata,
    input  logic                  i_period_end,
    output logic [31:0]           o_rdata,
    output logic                  o_enable,
    output logic                  o_mode,
    output logic [Resolution-1:0] o_period,
    output logic [Resolution-1:0] o_step,
    output logic [Resolution-1:0] o_thr1,
    output logic [Resolution-1:0] o_thr2,
    output logic [Resolution-1:0] o_inc,
    output logic                  o_commit
);

    logic                  r_sh_en;
    logic                  r_sh_mode;
    logic [Resolution-1:0] r_sh_period;
    logic [Resolution-1:0] r_sh_step;
    logic [Resolution-1:0] r_sh_thr1;
    logic [Resolution-1:0] r_sh_thr2;
    logic [Resolution-1:0] r_sh_inc;

    logic                  r_act_en;
    logic                  r_act_mode;
    logic [Resolution-1:0] r_act_period;
    logic [Resolution-1:0] r_act_step;
    logic [Resolution-1:0] r_act_thr1;
    logic [Resolution-1:0] r_act_thr2;
    logic [Resolution-1:0] r_act_inc;

    logic                  r_pending;
    logic                  r_commit;

    logic                  w_commit;
    logic                  w_set_update;
    logic [Resolution-1:0] w_data;

    assign w_data       = i_wdata[Resolution-1:0];
    // An idle channel has no period to protect, so it commits at once.
    assign w_commit     = r_pending && (!r_act_en || i_period_end);
    assign w_set_update = i_wr_en && (i_off == c_OFF_CTRL) && i_wdata[c_CTRL_UPD_BIT];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sh_en      <= 1'b0;
            r_sh_mode    <= 1'b0;
            r_sh_period  <= '0;
            r_sh_step    <= '0;
            r_sh_thr1    <= '0;
            r_sh_thr2    <= '0;
            r_sh_inc     <= '0;
            r_act_en     <= 1'b0;
            r_act_mode   <= 1'b0;
            r_act_period <= '0;
            r_act_step   <= '0;
            r_act_thr1   <= '0;
            r_act_thr2   <= '0;
            r_act_inc    <= '0;
            r_pending    <= 1'b0;
            r_commit     <= 1'b0;
        end else begin
            r_commit <= w_commit;

            if (w_commit) begin
                r_act_en     <= r_sh_en;
                r_act_mode   <= r_sh_mode;
                r_act_period <= r_sh_period;
                r_act_step   <= r_sh_step;
                r_act_thr1   <= r_sh_thr1;
                r_act_thr2   <= r_sh_thr2;
                r_act_inc    <= r_sh_inc;
            end

            if (i_wr_en) begin
                case (i_off)
                    c_OFF_CTRL: begin
                        r_sh_en   <= i_wdata[c_CTRL_EN_BIT];
                        r_sh_mode <= i_wdata[c_CTRL_MODE_BIT];
                    end
                    c_OFF_PERIOD: r_sh_period <= w_data;
                    c_OFF_STEP:   r_sh_step   <= w_data;
                    c_OFF_THR1:   r_sh_thr1   <= w_data;
                    c_OFF_THR2:   r_sh_thr2   <= w_data;
                    c_OFF_INC:    r_sh_inc    <= w_data;
                    default: ;
                endcase
            end

            // A fresh UPDATE wins over the clear from a simultaneous commit.
            if (w_set_update) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_off)
            c_OFF_CTRL: begin
                o_rdata[c_CTRL_EN_BIT]   = r_sh_en;
                o_rdata[c_CTRL_MODE_BIT] = r_sh_mode;
            end
            c_OFF_PERIOD: o_rdata = 32'(r_sh_period);
            c_OFF_STEP:   o_rdata = 32'(r_sh_step);
            c_OFF_THR1:   o_rdata = 32'(r_sh_thr1);
            c_OFF_THR2:   o_rdata = 32'(r_sh_thr2);
            c_OFF_INC:    o_rdata = 32'(r_sh_inc);
            c_OFF_STATUS: begin
                o_rdata[c_STAT_PEND_BIT] = r_pending;
                o_rdata[c_STAT_EN_BIT]   = r_act_en;
                o_rdata[c_STAT_MODE_BIT] = r_act_mode;
            end
            default: o_rdata = '0;
        endcase
    end

    assign o_enable = r_act_en;
    assign o_mode   = r_act_mode;
    assign o_period = r_act_period;
    assign o_step   = r_act_step;
    assign o_thr1   = r_act_thr1;
    assign o_thr2   = r_act_thr2;
    assign o_inc    = r_act_inc;
    assign o_commit = r_commit;

endmodule : pwm_ctrl_channel_regs
`default_nettype wire

// File: rtl/pwm_channel_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pwm_channel_ctrl : register port and safe-commit sequencer       |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module pwm_channel_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int NumCh      = 2,
    parameter int Resolution = 32,
    parameter int AddrW      = 6
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_we_i,
    input  logic [AddrW-1:0]            req_addr_i,
    input  logic [31:0]                 req_wdata_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [31:0]                 rsp_rdata_o,
    output logic                        rsp_err_o,
    input  logic [NumCh-1:0]            ch_period_end_i,
    output logic [NumCh-1:0]            ch_enable_o,
    output logic [NumCh-1:0]            ch_mode_o,
    output logic [NumCh*Resolution-1:0] ch_period_o,
    output logic [NumCh*Resolution-1:0] ch_step_o,
    output logic [NumCh*Resolution-1:0] ch_thr1_o,
    output logic [NumCh*Resolution-1:0] ch_thr2_o,
    output logic [NumCh*Resolution-1:0] ch_inc_o,
    output logic [NumCh-1:0]            ch_commit_o
);

    localparam int c_IDX_W = AddrW - 3;

    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;

    logic               w_accept;
    logic               w_wr_any;
    logic               w_ch_ok;
    logic [c_IDX_W-1:0] w_ch_idx;
    logic [2:0]         w_off;
    logic [31:0]        w_rd_sel;
    logic [31:0]        w_rdata_ch [NumCh];

    assign w_ch_idx    = req_addr_i[AddrW-1:3];
    assign w_off       = req_addr_i[2:0];
    assign w_ch_ok     = int'(w_ch_idx) < NumCh;
    assign req_ready_o = !r_rsp_valid || rsp_ready_i;
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_wr_any    = w_accept && req_we_i && w_ch_ok;

    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        logic w_wr_en;
        assign w_wr_en = w_wr_any && (int'(w_ch_idx) == c);

        pwm_ctrl_channel_regs #(
            .Resolution (Resolution)
        ) u_regs (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .i_wr_en      (w_wr_en),
            .i_off        (w_off),
            .i_wdata      (req_wdata_i),
            .i_period_end (ch_period_end_i[c]),
            .o_rdata      (w_rdata_ch[c]),
            .o_enable     (ch_enable_o[c]),
            .o_mode       (ch_mode_o[c]),
            .o_period     (ch_period_o[c*Resolution +: Resolution]),
            .o_step       (ch_step_o[c*Resolution +: Resolution]),
            .o_thr1       (ch_thr1_o[c*Resolution +: Resolution]),
            .o_thr2       (ch_thr2_o[c*Resolution +: Resolution]),
            .o_inc        (ch_inc_o[c*Resolution +: Resolution]),
            .o_commit     (ch_commit_o[c])
        );
    end

    always_comb begin
        w_rd_sel = '0;
        for (int c = 0; c < NumCh; c++) begin
            if (int'(w_ch_idx) == c) begin
                w_rd_sel = w_rdata_ch[c];
            end
        end
    end

    // Response register holds its contents until the consumer takes it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= c_RSP_OK;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (req_we_i || !w_ch_ok) ? 32'd0 : w_rd_sel;
            r_rsp_err   <= w_ch_ok ? c_RSP_OK : c_RSP_ERR_DECODE;
        end else if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;

endmodule : pwm_channel_ctrl
`default_nettype wire

// File: tb/tb_pwm_channel_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_pwm_channel_ctrl : scoreboard bench with reference model      |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_pwm_channel_ctrl;

    localparam int NUM = 2;
    localparam int RES = 32;
    localparam int AW  = 6;
    localparam logic [31:0] MASK = (RES == 32) ? 32'hFFFF_FFFF : ((32'd1 << RES) - 32'd1);

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                req_valid_i;
    logic                req_ready_o;
    logic                req_we_i;
    logic [AW-1:0]       req_addr_i;
    logic [31:0]         req_wdata_i;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [31:0]         rsp_rdata_o;
    logic                rsp_err_o;
    logic [NUM-1:0]      ch_period_end_i;
    logic [NUM-1:0]      ch_enable_o;
    logic [NUM-1:0]      ch_mode_o;
    logic [NUM*RES-1:0]  ch_period_o;
    logic [NUM*RES-1:0]  ch_step_o;
    logic [NUM*RES-1:0]  ch_thr1_o;
    logic [NUM*RES-1:0]  ch_thr2_o;
    logic [NUM*RES-1:0]  ch_inc_o;
    logic [NUM-1:0]      ch_commit_o;

    always #5 clk_i = ~clk_i;

    pwm_channel_ctrl #(.NumCh(NUM), .Resolution(RES), .AddrW(AW)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_we_i        (req_we_i),
        .req_addr_i      (req_addr_i),
        .req_wdata_i     (req_wdata_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_rdata_o     (rsp_rdata_o),
        .rsp_err_o       (rsp_err_o),
        .ch_period_end_i (ch_period_end_i),
        .ch_enable_o     (ch_enable_o),
        .ch_mode_o       (ch_mode_o),
        .ch_period_o     (ch_period_o),
        .ch_step_o       (ch_step_o),
        .ch_thr1_o       (ch_thr1_o),
        .ch_thr2_o       (ch_thr2_o),
        .ch_inc_o        (ch_inc_o),
        .ch_commit_o     (ch_commit_o)
    );

    // Reference model: shadow and active configuration per channel.
    // Field index 0..4 = period, step, thr1, thr2, inc (register offsets 1..5).
    typedef struct {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        q[$];
    logic        sh_en    [NUM];
    logic        sh_mode  [NUM];
    logic [31:0] sh_val   [NUM][5];
    logic        act_en   [NUM];
    logic        act_mode [NUM];
    logic [31:0] act_val  [NUM][5];
    logic        pend     [NUM];
    logic        m_commit [NUM];
    logic        m_rsp_valid;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(int c, int off);
        case (off)
            0:             return {30'd0, sh_mode[c], sh_en[c]};
            1, 2, 3, 4, 5: return sh_val[c][off-1];
            6:             return {29'd0, act_mode[c], act_en[c], pend[c]};
            default:       return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM; c++) begin
            sh_en[c] = 0; sh_mode[c] = 0; act_en[c] = 0; act_mode[c] = 0;
            pend[c] = 0; m_commit[c] = 0;
            for (int f = 0; f < 5; f++) begin
                sh_val[c][f] = 0; act_val[c][f] = 0;
            end
        end
        m_rsp_valid = 0;
        q.delete();
    endtask

    // Applied at each rising edge with the inputs that were held during the cycle.
    task automatic model_update();
        int   ch, off;
        logic bad, acc;
        rsp_t r;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        ch  = int'(req_addr_i[AW-1:3]);
        off = int'(req_addr_i[2:0]);
        bad = (ch >= NUM);
        acc = req_valid_i && (!m_rsp_valid || rsp_ready_i);
        if (acc) begin
            r.err  = bad;
            r.data = (req_we_i || bad) ? 32'd0 : model_read(ch, off);
            q.push_back(r);
            m_rsp_valid = 1;
        end else if (rsp_ready_i) begin
            m_rsp_valid = 0;
        end
        for (int c = 0; c < NUM; c++) begin
            m_commit[c] = pend[c] && (!act_en[c] || ch_period_end_i[c]);
            if (m_commit[c]) begin
                act_en[c] = sh_en[c]; act_mode[c] = sh_mode[c];
                for (int f = 0; f < 5; f++) act_val[c][f] = sh_val[c][f];
                pend[c] = 0;
            end
        end
        if (acc && req_we_i && !bad) begin
            if (off == 0) begin
                sh_en[ch]   = req_wdata_i[0];
                sh_mode[ch] = req_wdata_i[1];
                if (req_wdata_i[2]) pend[ch] = 1;
            end else if (off >= 1 && off <= 5) begin
                sh_val[ch][off-1] = req_wdata_i & MASK;
            end
        end
    endtask

    task automatic step(input logic v, input logic we, input logic [2:0] ch, input logic [2:0] off,
                        input logic [31:0] d, input logic rr, input logic [NUM-1:0] pe);
        req_valid_i     = v;
        req_we_i        = we;
        req_addr_i      = {ch, off};
        req_wdata_i     = d;
        rsp_ready_i     = rr;
        ch_period_end_i = pe;
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic wr(input logic [2:0] ch, input logic [2:0] off, input logic [31:0] d);
        step(1, 1, ch, off, d, 1, '0);
    endtask

    task automatic rd(input logic [2:0] ch, input logic [2:0] off);
        step(1, 0, ch, off, 32'd0, 1, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 3'd0, 3'd0, 32'd0, 1, '0);
    endtask

    // Monitor: compares outputs against the model mid-cycle.
    always @(negedge clk_i) begin
        if (chk_en) begin
            for (int c = 0; c < NUM; c++) begin
                chk($sformatf("ch%0d_enable", c), 32'(ch_enable_o[c]), 32'(act_en[c]));
                chk($sformatf("ch%0d_mode", c),   32'(ch_mode_o[c]),   32'(act_mode[c]));
                chk($sformatf("ch%0d_period", c), ch_period_o[c*RES +: RES], act_val[c][0]);
                chk($sformatf("ch%0d_step", c),   ch_step_o[c*RES +: RES],   act_val[c][1]);
                chk($sformatf("ch%0d_thr1", c),   ch_thr1_o[c*RES +: RES],   act_val[c][2]);
                chk($sformatf("ch%0d_thr2", c),   ch_thr2_o[c*RES +: RES],   act_val[c][3]);
                chk($sformatf("ch%0d_inc", c),    ch_inc_o[c*RES +: RES],    act_val[c][4]);
                chk($sformatf("ch%0d_commit", c), 32'(ch_commit_o[c]), 32'(m_commit[c]));
            end
            chk("req_ready", 32'(req_ready_o), 32'(!m_rsp_valid || rsp_ready_i));
            chk("rsp_valid", 32'(rsp_valid_o), 32'(m_rsp_valid));
            if (m_rsp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_queue: got empty scoreboard, expected a response");
                end else begin
                    chk("rsp_rdata", rsp_rdata_o, q[0].data);
                    chk("rsp_err", 32'(rsp_err_o), 32'(q[0].err));
                    if (rsp_ready_i) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0;
        model_reset();
        idle(2);
        chk_en = 1'b1;
        chk("reset_rdata", rsp_rdata_o, 32'd0);
        chk("reset_err", 32'(rsp_err_o), 32'd0);
        rst_ni = 1'b1;
        idle(2);

        // Idle channel commits the cycle after UPDATE.
        wr(0, 1, 100); wr(0, 3, 20); wr(0, 4, 80); wr(0, 2, 1); wr(0, 5, 5);
        wr(0, 0, 7);
        idle(3);

        // Enabled channel waits for its period end.
        wr(0, 3, 30); wr(0, 0, 7);
        idle(50);
        rd(0, 6);
        step(0, 0, 0, 0, 0, 1, 2'b01);
        idle(1);
        rd(0, 6); rd(0, 3);

        // Shadow write coincident with the commit.
        wr(0, 0, 7);
        step(1, 1, 0, 4, 90, 1, 2'b01);
        idle(1);
        rd(0, 4);

        // Back-pressure on the response, then back-to-back reads.
        step(1, 0, 0, 1, 0, 0, '0);
        step(1, 0, 0, 3, 0, 0, '0);
        step(1, 0, 0, 3, 0, 0, '0);
        step(1, 0, 0, 3, 0, 1, '0);
        rd(0, 1); rd(0, 2); rd(0, 5);
        idle(1);

        // Decode error, reserved and read-only offsets.
        wr(3, 1, 55); rd(3, 1); rd(2, 0);
        wr(0, 7, 123); rd(0, 7);
        wr(0, 6, 32'hFF); rd(0, 6);
        wr(1, 1, 50); wr(1, 0, 1); idle(2); rd(1, 6);

        // UPDATE write in the very cycle of a commit.
        wr(0, 0, 7);
        step(1, 1, 0, 0, 7, 1, 2'b01);
        rd(0, 6);
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            logic [NUM-1:0] pe;
            for (int c = 0; c < NUM; c++) pe[c] = ($urandom_range(0, 5) == 0);
            step(($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 3) != 0), pe);
        end

        // Reset while a commit is pending and a response is outstanding.
        idle(1);
        wr(0, 0, 7);
        step(0, 0, 0, 0, 0, 1, 2'b01);
        step(0, 0, 0, 0, 0, 1, 2'b01);
        idle(1);
        step(1, 1, 0, 0, 7, 0, '0);
        rst_ni = 1'b0;
        step(0, 0, 0, 0, 0, 0, '0);
        chk("rst_mid_rdata", rsp_rdata_o, 32'd0);
        chk("rst_mid_err", 32'(rsp_err_o), 32'd0);
        rst_ni = 1'b1;
        idle(2);
        rd(0, 6);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pwm_channel_ctrl
`default_nettype wire
